// File: rtl/io_ctrl.sv
// Purpose: IO register window 0x08-0x0F: GPIO with edge capture, prescaled 8-bit timer, level irq.
// Latency: readdata is registered, valid one cycle after readaddr; writes land on the write_en edge.
// Backpressure: none; every write and read completes in one cycle, no stall path.
// Ports: clk/reset (async active-low); writeaddr/writedata/write_en shared with the memory controller;
//        readaddr -> readdata (next cycle); gpio_in (async pins), gpio_out/gpio_oe; irq level request.
module io_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] writeaddr,
  input  logic [7:0] writedata,
  input  logic       write_en,
  input  logic [7:0] readaddr,
  output logic [7:0] readdata,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic [7:0] gpio_oe,
  output logic       irq
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] gpio_in_s;
  logic [7:0] gpio_prev;
  logic [7:0] edge_stat;
  logic [7:0] tmr_cnt;
  logic [7:0] tmr_rld;
  logic [5:0] tmr_ctrl;
  logic       tmr_ovf;
  logic [5:0] presc;

  logic       wr_win;
  logic       wr_out, wr_dir, wr_cnt, wr_rld, wr_ctrl, wr_stat, wr_edge;
  logic       tick_due, tick;
  logic [7:0] cnt_nxt;
  logic [5:0] ctrl_nxt;
  logic       ovf_nxt;
  logic [7:0] edge_nxt;
  logic [7:0] rd_mux;

  assign gpio_in_s = sync_q[SYNC_STAGES-1];

  assign wr_win  = write_en && (writeaddr[7:3] == 5'b00001);
  assign wr_out  = wr_win && (writeaddr[2:0] == 3'd0);
  assign wr_dir  = wr_win && (writeaddr[2:0] == 3'd2);
  assign wr_cnt  = wr_win && (writeaddr[2:0] == 3'd3);
  assign wr_rld  = wr_win && (writeaddr[2:0] == 3'd4);
  assign wr_ctrl = wr_win && (writeaddr[2:0] == 3'd5);
  assign wr_stat = wr_win && (writeaddr[2:0] == 3'd6);
  assign wr_edge = wr_win && (writeaddr[2:0] == 3'd7);

  // Prescaler terminal count per psel: every 1, 4, 16 or 64 enabled clocks.
  always_comb begin
    tick_due = 1'b0;
    case (tmr_ctrl[3:2])
      2'd0: tick_due = 1'b1;
      2'd1: tick_due = &presc[1:0];
      2'd2: tick_due = &presc[3:0];
      2'd3: tick_due = &presc;
      default: tick_due = 1'b0;
    endcase
  end

  assign tick = tmr_ctrl[0] && tick_due;

  // Timer and flag next-state. Order matters: tick effects first, then
  // register writes override, then flag sets override W1C clears.
  always_comb begin
    cnt_nxt  = tmr_cnt;
    ctrl_nxt = tmr_ctrl;
    ovf_nxt  = tmr_ovf;
    edge_nxt = edge_stat;

    if (tick) begin
      if (tmr_cnt != 8'hFF) begin
        cnt_nxt = tmr_cnt + 8'd1;
      end else if (tmr_ctrl[1]) begin
        cnt_nxt = tmr_rld;  // pre-write reload value even if TMR_RLD is written now
      end else begin
        cnt_nxt     = 8'h00;
        ctrl_nxt[0] = 1'b0;  // one-shot stops itself
      end
    end

    if (wr_cnt)  cnt_nxt  = writedata;
    if (wr_ctrl) ctrl_nxt = writedata[5:0];
    if (wr_stat) ovf_nxt  = tmr_ovf & ~writedata[0];
    if (wr_edge) edge_nxt = edge_stat & ~writedata;

    if (tick && (tmr_cnt == 8'hFF)) ovf_nxt = 1'b1;
    edge_nxt = edge_nxt | (gpio_in_s & ~gpio_prev);
  end

  // Read mux samples pre-write state, so a same-cycle write reads back the old value.
  always_comb begin
    rd_mux = 8'h00;
    case (readaddr)
      8'h08: rd_mux = gpio_out;
      8'h09: rd_mux = gpio_in_s;
      8'h0A: rd_mux = gpio_oe;
      8'h0B: rd_mux = tmr_cnt;
      8'h0C: rd_mux = tmr_rld;
      8'h0D: rd_mux = {2'b00, tmr_ctrl};
      8'h0E: rd_mux = {7'd0, tmr_ovf};
      8'h0F: rd_mux = edge_stat;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      gpio_prev <= 8'h00;
      edge_stat <= 8'h00;
      gpio_out  <= 8'h00;
      gpio_oe   <= 8'h00;
      tmr_cnt   <= 8'h00;
      tmr_rld   <= 8'h00;
      tmr_ctrl  <= 6'd0;
      tmr_ovf   <= 1'b0;
      presc     <= 6'd0;
      readdata  <= 8'h00;
      irq       <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      gpio_prev <= gpio_in_s;
      edge_stat <= edge_nxt;
      tmr_cnt   <= cnt_nxt;
      tmr_ctrl  <= ctrl_nxt;
      tmr_ovf   <= ovf_nxt;
      readdata  <= rd_mux;
      if (wr_out) gpio_out <= writedata;
      if (wr_dir) gpio_oe  <= writedata;
      if (wr_rld) tmr_rld  <= writedata;
      // A TMR_CNT write does not disturb the prescaler; only disable or a CTRL write restarts it.
      if (!tmr_ctrl[0] || wr_ctrl) presc <= 6'd0;
      else                         presc <= presc + 6'd1;
      irq <= (tmr_ovf & tmr_ctrl[4]) | ((|edge_stat) & tmr_ctrl[5]);
    end
  end

endmodule

// File: tb/tb_io_ctrl.sv
// Purpose: scoreboard bench for io_ctrl against a cycle reference model built from the register rules.
// Latency: expectations pushed at each rising edge, popped and compared 1 time unit later.
// Backpressure: none; one expectation per clock, an empty queue counts as a failed check.
module tb_io_ctrl;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] writeaddr = 8'h00;
  logic [7:0] writedata = 8'h00;
  logic       write_en = 1'b0;
  logic [7:0] readaddr = 8'h00;
  logic [7:0] readdata;
  logic [7:0] gpio_in = 8'h00;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic       irq;

  io_ctrl #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset),
    .writeaddr(writeaddr), .writedata(writedata), .write_en(write_en),
    .readaddr(readaddr), .readdata(readdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] rd;
    logic [7:0] out;
    logic [7:0] oe;
    logic       irq;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass = 0;

  // Reference model state: register file as plain variables, pin history as a queue
  // (samp[0] = most recently sampled pins), prescaler as a count of enabled clocks.
  logic [7:0] m_out, m_dir, m_cnt, m_rld, m_edge;
  logic [5:0] m_ctrl;
  logic       m_ovf;
  int         m_ecount;
  logic [7:0] samp[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at t=%0t", name, act, exp, $time);
  endtask

  task automatic m_clear();
    m_out = 0; m_dir = 0; m_cnt = 0; m_rld = 0; m_edge = 0;
    m_ctrl = 0; m_ovf = 0; m_ecount = 0;
    samp = {};
    for (int i = 0; i <= S; i++) samp.push_back(8'h00);
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h08: return m_out;
      8'h09: return samp[S-1];
      8'h0A: return m_dir;
      8'h0B: return m_cnt;
      8'h0C: return m_rld;
      8'h0D: return {2'b00, m_ctrl};
      8'h0E: return {7'd0, m_ovf};
      8'h0F: return m_edge;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_step();
    exp_t e;
    logic en, ar, tick, wr;
    logic [7:0] cnt_n, edge_n;
    logic [5:0] ctrl_n;
    logic ovf_n, ovf_set;
    int period;
    e.rd  = m_read(readaddr);
    e.irq = (m_ovf & m_ctrl[4]) | ((m_edge != 0) & m_ctrl[5]);
    en = m_ctrl[0];
    ar = m_ctrl[1];
    period = 1 << (2 * int'(m_ctrl[3:2]));
    tick = en && ((m_ecount % period) == period - 1);
    wr = write_en && (writeaddr >= 8'h08) && (writeaddr <= 8'h0F);
    cnt_n = m_cnt; ctrl_n = m_ctrl; ovf_n = m_ovf; edge_n = m_edge; ovf_set = 0;
    if (tick) begin
      if (m_cnt != 8'hFF) cnt_n = m_cnt + 8'd1;
      else begin
        ovf_set = 1;
        if (ar) cnt_n = m_rld;
        else begin cnt_n = 8'h00; ctrl_n[0] = 1'b0; end
      end
    end
    m_ecount = (!en || (wr && writeaddr == 8'h0D)) ? 0 : (m_ecount + 1) % 64;
    if (wr) begin
      case (writeaddr)
        8'h08: m_out = writedata;
        8'h0A: m_dir = writedata;
        8'h0B: cnt_n = writedata;
        8'h0C: m_rld = writedata;
        8'h0D: ctrl_n = writedata[5:0];
        8'h0E: ovf_n = m_ovf & ~writedata[0];
        8'h0F: edge_n = m_edge & ~writedata;
        default: ;
      endcase
    end
    // rising edge on the synchronised pins: was 0 one sample earlier, is 1 now
    edge_n = edge_n | (samp[S-1] & ~samp[S]);
    m_cnt = cnt_n; m_ctrl = ctrl_n; m_ovf = ovf_n | ovf_set; m_edge = edge_n;
    samp.push_front(gpio_in);
    samp.delete(S + 1);
    e.out = m_out;
    e.oe  = m_dir;
    q.push_back(e);
  endtask

  // Model: advances on every rising edge, clears on asynchronous reset.
  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_clear();
        if (clk) q.push_back('0);
      end else begin
        m_step();
      end
    end
  end

  // Monitor: one expectation per rising edge, compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty: no expectation queued at t=%0t", $time);
      end else begin
        e = q.pop_front();
        check("readdata", readdata, e.rd);
        check("gpio_out", gpio_out, e.out);
        check("gpio_oe",  gpio_oe,  e.oe);
        check("irq", {7'd0, irq}, {7'd0, e.irq});
      end
    end
  end

  task automatic drive(input logic we, input logic [7:0] wa, input logic [7:0] wd, input logic [7:0] ra);
    write_en = we; writeaddr = wa; writedata = wd; readaddr = ra;
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    drive(1'b1, a, d, a);
  endtask

  task automatic rd(input logic [7:0] a);
    drive(1'b0, 8'h00, 8'h00, a);
  endtask

  initial begin
    logic [7:0] wa, wd;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // reset state of every register
    for (int a = 8; a < 16; a++) rd(8'(a));
    rd(8'h00);

    // GPIO output and direction
    wr(8'h08, 8'hA5);
    wr(8'h0A, 8'h0F);
    rd(8'h08); rd(8'h0A); rd(8'h20);

    // edge capture with eie, then W1C
    wr(8'h0D, 8'h20);
    gpio_in = 8'h08;
    repeat (4) rd(8'h09);
    repeat (2) rd(8'h0F);
    wr(8'h0F, 8'h08);
    repeat (3) rd(8'h0F);
    gpio_in = 8'h00;

    // autoreload overflow, psel=0, tie
    wr(8'h0C, 8'hF0);
    wr(8'h0B, 8'hFE);
    wr(8'h0D, 8'h13);
    repeat (4) rd(8'h0B);
    rd(8'h0D); rd(8'h0E);
    wr(8'h0D, 8'h00);
    wr(8'h0E, 8'h01);

    // one-shot, psel=1
    wr(8'h0B, 8'hFD);
    wr(8'h0D, 8'h05);
    repeat (16) rd(8'h0B);
    rd(8'h0D); rd(8'h0E);

    // overflow coincident with W1C of ovf
    wr(8'h0E, 8'h01);
    wr(8'h0B, 8'hFF);
    wr(8'h0D, 8'h11);
    wr(8'h0E, 8'h01);
    repeat (2) rd(8'h0E);

    // TMR_RLD written in the overflow cycle: old reload value is used
    wr(8'h0C, 8'h40);
    wr(8'h0B, 8'hFF);
    wr(8'h0D, 8'h03);
    wr(8'h0C, 8'h80);
    repeat (2) rd(8'h0B);
    wr(8'h0D, 8'h00);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
      wa = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(8 + $urandom_range(0, 7));
      wd = 8'($urandom);
      if (wa == 8'h0B && $urandom_range(0, 1) == 1) wd = 8'hF0 | 8'($urandom_range(0, 15));
      drive($urandom_range(0, 9) < 4, wa, wd, 8'($urandom_range(0, 31)));
    end

    // reset asserted mid-count with irq high
    rd(8'h00);
    wr(8'h08, 8'h5A);
    wr(8'h0A, 8'hFF);
    wr(8'h0B, 8'hFF);
    wr(8'h0D, 8'h11);
    wr(8'h0B, 8'h10);
    wr(8'h0D, 8'h19);
    drive(1'b0, 8'h00, 8'h00, 8'h0B);
    repeat (20) rd(8'h0B);
    #2 reset = 1'b0;
    #1;
    check("rst_irq", {7'd0, irq}, 8'h00);
    check("rst_gpio_out", gpio_out, 8'h00);
    check("rst_gpio_oe", gpio_oe, 8'h00);
    check("rst_readdata", readdata, 8'h00);
    @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd(8'h0B); rd(8'h0D); rd(8'h0E); rd(8'h08);
    repeat (3) rd(8'h00);

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/io_ctrl.md
Name: io_ctrl

Overview:
- Implements the IO register window 0x08–0x0F of the data address space, which the memory controller currently decodes and returns as zero.
- Sits beside the memory controller on the same write port (writeaddr/writedata/write_en) and read address.
- Returns read data one cycle after the address, matching the memory controller's registered-address timing, so the controller can mux it in for addresses 0x08–0x0F.
- Provides an 8-bit GPIO port with rising-edge capture, an 8-bit prescaled timer, and a level interrupt request to the interrupt logic.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on gpio_in; legal values are 2 or greater.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- writeaddr  input  8  data write address
- writedata  input  8  data write value
- write_en  input  1  write strobe, one cycle per write
- readaddr  input  8  data read address
- readdata  output  8  read value for the readaddr of the previous cycle
- gpio_in  input  8  asynchronous external pins
- gpio_out  output  8  GPIO_OUT register value
- gpio_oe  output  8  GPIO_DIR register value; 1 = output
- irq  output  1  registered interrupt request, level

Behaviour:
- Register map:
  - 0x08 GPIO_OUT: R/W.
  - 0x09 GPIO_IN: RO, synchronised pins.
  - 0x0A GPIO_DIR: R/W.
  - 0x0B TMR_CNT: R/W.
  - 0x0C TMR_RLD: R/W.
  - 0x0D TMR_CTRL: R/W. Bit0 en, bit1 autoreload, bits3:2 psel, bit4 tie, bit5 eie, bits7:6 read 0.
  - 0x0E TMR_STAT: bit0 ovf, write-1-to-clear; other bits read 0.
  - 0x0F EDGE_STAT: one flag per pin, write-1-to-clear.
- Reset (reset==0, asynchronous):
  - All registers, the prescaler, the synchroniser, the edge history and readdata go to 0.
  - irq goes to 0.
- Write: takes effect at the rising edge where write_en=1 and writeaddr is in 0x08–0x0F. Writes outside the window are ignored. A write to 0x09 is ignored.
- Read:
  - The readaddr is registered.
  - readdata is the selected register value, registered, one cycle later.
  - readdata is 0 when the registered address is outside 0x08–0x0F.
  - A same-cycle write to the read address returns the pre-write value. The memory controller's forwarding path covers the bypass.
- GPIO_IN is the output of a SYNC_STAGES-deep flop chain.
- Edge capture: a pin with previous synchronised value 0 and current value 1 sets its EDGE_STAT bit.
- Prescaler:
  - Free-running 6-bit counter while en=1.
  - tick = 1 every 1, 4, 16 or 64 clocks for psel 0/1/2/3.
  - psel=0 ticks every cycle while en=1.
  - The prescaler clears when en=0 and on any TMR_CTRL write.
- Timer, on tick:
  - If TMR_CNT != 0xFF, TMR_CNT increments by 1.
  - If TMR_CNT == 0xFF, ovf is set.
  - On that overflow with autoreload=1, TMR_CNT is loaded from TMR_RLD.
  - On that overflow with autoreload=0, TMR_CNT becomes 0x00 and en clears (one-shot).
- Simultaneous events:
  - A TMR_CNT write and a tick in the same cycle: the write wins and the prescaler is unaffected.
  - A TMR_CTRL write and an overflow in the same cycle: the written value wins for en.
  - A W1C write and a flag set in the same cycle: set wins (flag stays 1).
  - A TMR_RLD write during the overflow cycle: the old TMR_RLD is loaded.
- irq: registered, irq <= (ovf & tie) | ((|EDGE_STAT) & eie). It rises one cycle after the flag is set and falls one cycle after the clearing write. It is a level, not a pulse.
- Reset asserted mid-count: the count is lost and the timer is disabled.

Test Plan:
- Reset, then read each of 0x08–0x0F on successive cycles -> readdata 0x00 each, one cycle after each address; irq=0.
- Write GPIO_OUT=0xA5, GPIO_DIR=0x0F; read both back -> gpio_out=0xA5, gpio_oe=0x0F on the cycle after the write; reads return 0xA5 and 0x0F.
- Drive gpio_in bit3 0->1 -> GPIO_IN reads 0x08 after SYNC_STAGES+1 cycles; EDGE_STAT=0x08. With eie=1, irq=1 one cycle later. Write 0x08 to 0x0F -> EDGE_STAT=0x00, irq=0 one cycle after.
- TMR_RLD=0xF0, TMR_CNT=0xFE, TMR_CTRL=0x13 (en, autoreload, psel=0, tie) -> CNT goes 0xFF, then 0xF0 with ovf=1; irq=1 the cycle after; en stays 1.
- TMR_CNT=0xFD, TMR_CTRL=0x05 (one-shot, psel=1) -> CNT advances every 4 clocks; at overflow CNT=0x00, ovf=1, TMR_CTRL reads 0x04.
- Overflow in the same cycle as a W1C write of 0x01 to 0x0E -> ovf remains 1. Assert reset mid-count -> CNT=0, CTRL=0, irq=0 immediately, without waiting for a clock edge.
